// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : RV32I instruction-fetch stage with the IF/ID pipeline
//               register. Owns the PC and issues fetches on a single-
//               outstanding-request instruction memory port. It registers
//               the fetched word and presents the decoded fields (opcode,
//               funct3, funct7, rd, rs1, rs2) together with the PC to the
//               ID stage. It also handles ID stalls and branch/jump
//               redirects, including squashing of an in-flight fetch.
//
// Parameters  : RESET_PC    - PC after reset and first fetch address
//               NOP_INSTR   - word shown on id_instr when invalid/flushed
//
// Ports       : clk, rst                   - clock, async active-high reset
//               stall_id                   - ID cannot accept; hold IF/ID
//               redirect, redirect_pc      - taken branch/jump and target
//               imem_req/addr/gnt          - fetch request channel
//               imem_rvalid/rdata          - fetch response channel
//               id_valid/id_pc/id_instr    - IF/ID register contents
//               opcode/funct3/funct7       - decoded fields to ctrl_unit
//               rd/rs1/rs2                 - register indices to ID
//               id_misalign                - (IFID_MISALIGN_TRAP_EN only)
//                                            misaligned redirect target
//
// Options     : `define IFID_MISALIGN_TRAP_EN to report misaligned redirect
//               targets through id_misalign instead of masking them.
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
`ifdef IFID_MISALIGN_TRAP_EN
  output logic        id_misalign,
`endif
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request presented, waiting for grant
    S_RESP = 2'd1,  // request accepted, waiting for read data
    S_HOLD = 2'd2   // word returned but IF/ID is blocked by a stall
  } state_t;

  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;     // address of the outstanding fetch
  logic        kill_q, kill_d;             // discard the next response
  logic [31:0] hold_instr_q, hold_instr_d; // word parked while ID stalls
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
`ifdef IFID_MISALIGN_TRAP_EN
  logic        misalign_pend_q, misalign_pend_d;
  logic [31:0] misalign_pc_q, misalign_pc_d;
  logic        id_misalign_q, id_misalign_d;
`endif

  logic        w_if_free;
  logic        w_hs;
  logic [31:0] w_redirect_aligned;
  logic [31:0] w_redirect_next_pc;

  // --------------------------------------------------------------------------
  // Memory request side
  // --------------------------------------------------------------------------
  always_comb begin
    // While reset is held the state already reads S_REQ; the request is
    // masked so nothing leaves the stage until reset is released.
`ifdef IFID_MISALIGN_TRAP_EN
    // A pending misalign report is delivered without a memory access.
    imem_req = (state_q == S_REQ) && !rst && !misalign_pend_q;
`else
    imem_req = (state_q == S_REQ) && !rst;
`endif
    imem_addr = pc_q;
    w_hs      = imem_req && imem_gnt;
    w_if_free = !id_valid_q || !stall_id;
    // The AND keeps every bit of redirect_pc in the expression; the low two
    // bits are dropped here rather than by slicing.
    w_redirect_aligned = redirect_pc & c_align_mask;
`ifdef IFID_MISALIGN_TRAP_EN
    // Misaligned target: the report occupies the target slot, so fetching
    // resumes at the following word.
    w_redirect_next_pc = (redirect_pc[1:0] != 2'b00) ? (w_redirect_aligned + 32'd4)
                                                     : w_redirect_aligned;
`else
    w_redirect_next_pc = w_redirect_aligned;
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
`ifdef IFID_MISALIGN_TRAP_EN
    misalign_pend_d = misalign_pend_q;
    misalign_pc_d   = misalign_pc_q;
    id_misalign_d   = id_misalign_q;
`endif

    // ID consumes the held instruction on any non-stalled valid cycle; a
    // load later in this block re-validates the register.
    if (id_valid_q && !stall_id) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (w_hs) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;  // wraps FFFF_FFFC -> 0000_0000
          state_d    = S_RESP;
        end
`ifdef IFID_MISALIGN_TRAP_EN
        else if (misalign_pend_q && w_if_free) begin
          id_valid_d      = 1'b1;
          id_instr_d      = NOP_INSTR;
          id_pc_d         = misalign_pc_q;
          id_misalign_d   = 1'b1;
          misalign_pend_d = 1'b0;
        end
`endif
      end

      S_RESP: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (w_if_free) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = fetch_pc_q;
`ifdef IFID_MISALIGN_TRAP_EN
            id_misalign_d = 1'b0;
`endif
            state_d    = S_REQ;
          end else begin
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // fetch_pc_q is untouched since the grant, so it still tags the
        // parked word.
        if (w_if_free) begin
          id_valid_d = 1'b1;
          id_instr_d = hold_instr_q;
          id_pc_d    = fetch_pc_q;
`ifdef IFID_MISALIGN_TRAP_EN
          id_misalign_d = 1'b0;
`endif
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect overrides everything above: flush IF/ID (even when stalled)
    // and steer the PC. A fetch already granted must have its response
    // discarded, unless that response is arriving right now.
    if (redirect) begin
      pc_d       = w_redirect_next_pc;
      id_valid_d = 1'b0;
`ifdef IFID_MISALIGN_TRAP_EN
      misalign_pend_d = (redirect_pc[1:0] != 2'b00);
      misalign_pc_d   = redirect_pc;
`endif
      case (state_q)
        S_REQ: begin
          if (w_hs) begin
            kill_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
        S_RESP: begin
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = S_RESP;
          end
        end
        default: begin
          // S_HOLD: the parked word is simply abandoned.
          state_d = S_REQ;
        end
      endcase
    end

    // An empty IF/ID register always shows the NOP so the decoded fields
    // are benign.
    if (!id_valid_d) begin
      id_instr_d = NOP_INSTR;
`ifdef IFID_MISALIGN_TRAP_EN
      id_misalign_d = 1'b0;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC & c_align_mask;
      fetch_pc_q   <= RESET_PC & c_align_mask;
      kill_q       <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      id_valid_q   <= 1'b0;
      id_pc_q      <= RESET_PC;
      id_instr_q   <= NOP_INSTR;
`ifdef IFID_MISALIGN_TRAP_EN
      misalign_pend_q <= 1'b0;
      misalign_pc_q   <= RESET_PC;
      id_misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
`ifdef IFID_MISALIGN_TRAP_EN
      misalign_pend_q <= misalign_pend_d;
      misalign_pc_q   <= misalign_pc_d;
      id_misalign_q   <= id_misalign_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
`ifdef IFID_MISALIGN_TRAP_EN
  assign id_misalign = id_misalign_q;
`endif

  assign opcode = id_instr_q[6:0];
  assign rd     = id_instr_q[11:7];
  assign funct3 = id_instr_q[14:12];
  assign rs1    = id_instr_q[19:15];
  assign rs2    = id_instr_q[24:20];
  assign funct7 = id_instr_q[31:25];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Directed self-checking bench for if_id_stage. The bench
//               plays the instruction memory by hand, cycle by cycle, and
//               compares the stage outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef IFID_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
`ifdef IFID_MISALIGN_TRAP_EN
    .id_misalign (id_misalign),
`endif
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2)
  );

  // Advance one clock; outputs are then examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // From S_REQ with gnt high: grant now, return data on the next cycle.
  task automatic fetch_one(input logic [31:0] data);
    tick();
    imem_rvalid = 1'b1; imem_rdata = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", id_valid); end
    n_vec++; if (id_instr !== NOP) begin n_err++; $display("FAIL rst_instr: got %08h want %08h", id_instr, NOP); end
    n_vec++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %08h want 0", id_pc); end
    n_vec++; if ({funct7, funct3, opcode} !== {7'h00, 3'h0, 7'h13}) begin n_err++;
      $display("FAIL rst_fields: got f7=%0h f3=%0h op=%0h want 0 0 13", funct7, funct3, opcode); end
`ifdef IFID_MISALIGN_TRAP_EN
    n_vec++; if (id_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %0b want 0", id_misalign); end
`endif
    rst = 1'b0;
    #1;
  endtask

  task automatic test_basic_fetch();
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++;
      $display("FAIL first_req: got req=%0b addr=%08h want 1 0", imem_req, imem_addr); end
    tick();  // grant of 0x0
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL resp_noreq: got %0b want 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, 32'h0000_0033}) begin n_err++;
      $display("FAIL add_load: got v=%0b pc=%08h i=%08h want 1 0 00000033", id_valid, id_pc, id_instr); end
    n_vec++; if ({opcode, funct3, funct7} !== {7'b0110011, 3'h0, 7'h00}) begin n_err++;
      $display("FAIL add_fields: got op=%0h f3=%0h f7=%0h want 33 0 0", opcode, funct3, funct7); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin n_err++;
      $display("FAIL second_req: got req=%0b addr=%08h want 1 4", imem_req, imem_addr); end
    tick();  // grant of 0x4, add consumed
    n_vec++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_err++;
      $display("FAIL consumed: got v=%0b i=%08h want 0 %08h", id_valid, id_instr, NOP); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_2003;
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if ({id_pc, id_instr, funct3, opcode} !== {32'h4, 32'h0000_2003, 3'b010, 7'b0000011}) begin n_err++;
      $display("FAIL lw_load: got pc=%08h i=%08h f3=%0h op=%0h want 4 00002003 2 3", id_pc, id_instr, funct3, opcode); end
    n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL third_req: got %08h want 8", imem_addr); end
  endtask

  task automatic test_stall();
    stall_id = 1'b1;
    tick();  // grant of 0x8 while lw is held
    n_vec++; if ({id_valid, id_pc, id_instr, imem_req} !== {1'b1, 32'h4, 32'h0000_2003, 1'b0}) begin n_err++;
      $display("FAIL stall1: got v=%0b pc=%08h i=%08h req=%0b want 1 4 00002003 0", id_valid, id_pc, id_instr, imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();  // word parked
    imem_rvalid = 1'b0;
    n_vec++; if ({id_instr, imem_req} !== {32'h0000_2003, 1'b0}) begin n_err++;
      $display("FAIL stall2: got i=%08h req=%0b want 00002003 0", id_instr, imem_req); end
    tick();
    n_vec++; if ({id_valid, id_pc, imem_req} !== {1'b1, 32'h4, 1'b0}) begin n_err++;
      $display("FAIL stall3: got v=%0b pc=%08h req=%0b want 1 4 0", id_valid, id_pc, imem_req); end
    stall_id = 1'b0;
    tick();  // parked word moves in
    n_vec++; if ({id_valid, id_pc, id_instr, rd, rs1} !== {1'b1, 32'h8, 32'h00A0_0093, 5'd1, 5'd0}) begin n_err++;
      $display("FAIL unstall: got v=%0b pc=%08h i=%08h rd=%0d rs1=%0d want 1 8 00a00093 1 0", id_valid, id_pc, id_instr, rd, rs1); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin n_err++;
      $display("FAIL unstall_req: got req=%0b addr=%08h want 1 c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    apply_reset();
    fetch_one(32'h0000_0033);
    fetch_one(32'h0000_2003);
    tick();  // grant of 0x8
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_vec++; if ({imem_req, id_valid} !== {1'b0, 1'b0}) begin n_err++;
      $display("FAIL redir_wait: got req=%0b v=%0b want 0 0", imem_req, id_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0080_0113;  // stale response for 0x8
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_err++;
      $display("FAIL redir_drop: got v=%0b i=%08h want 0 %08h", id_valid, id_instr, NOP); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_err++;
      $display("FAIL redir_req: got req=%0b addr=%08h want 1 100", imem_req, imem_addr); end
    tick();  // grant of 0x100
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_early: got %0b want 0", id_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h4020_8033;  // sub x0,x1,x2
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if ({id_valid, id_pc, funct7, rs1, rs2} !== {1'b1, 32'h100, 7'h20, 5'd1, 5'd2}) begin n_err++;
      $display("FAIL redir_load: got v=%0b pc=%08h f7=%0h rs1=%0d rs2=%0d want 1 100 20 1 2", id_valid, id_pc, funct7, rs1, rs2); end
  endtask

  task automatic test_gnt_wait();
    stall_id = 1'b1; imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if ({imem_req, imem_addr, id_valid, id_pc} !== {1'b1, 32'h104, 1'b1, 32'h100}) begin n_err++;
        $display("FAIL gnt_wait%0d: got req=%0b addr=%08h v=%0b pc=%08h want 1 104 1 100", i, imem_req, imem_addr, id_valid, id_pc); end
    end
    imem_gnt = 1'b1; stall_id = 1'b0;
    fetch_one(32'h0010_0093);
    n_vec++; if ({id_pc, id_instr} !== {32'h104, 32'h0010_0093}) begin n_err++;
      $display("FAIL gnt_load: got pc=%08h i=%08h want 104 00100093", id_pc, id_instr); end
  endtask

  task automatic test_redirect_rvalid();
    tick();  // grant of 0x108
    tick(); tick();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL slow_resp: got req=%0b want 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0293;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    imem_rvalid = 1'b0; redirect = 1'b0;
    n_vec++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_err++;
      $display("FAIL rr_drop: got v=%0b i=%08h want 0 %08h", id_valid, id_instr, NOP); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin n_err++;
      $display("FAIL rr_req: got req=%0b addr=%08h want 1 200", imem_req, imem_addr); end
    fetch_one(32'h0020_0113);
    n_vec++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h200, 32'h0020_0113}) begin n_err++;
      $display("FAIL rr_load: got v=%0b pc=%08h i=%08h want 1 200 00200113", id_valid, id_pc, id_instr); end
    tick();  // grant of 0x204, held word consumed
    n_vec++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_err++;
      $display("FAIL rr_nodup: got v=%0b i=%08h want 0 %08h", id_valid, id_instr, NOP); end
  endtask

  task automatic test_reset_midfetch();
    rst = 1'b1;
    #1;
    n_vec++; if ({imem_req, id_valid, id_instr, id_pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin n_err++;
      $display("FAIL mid_rst: got req=%0b v=%0b i=%08h pc=%08h want 0 0 %08h 0", imem_req, id_valid, id_instr, id_pc, NOP); end
    tick();
    rst = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;  // stray response
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_err++;
      $display("FAIL stray: got v=%0b i=%08h want 0 %08h", id_valid, id_instr, NOP); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++;
      $display("FAIL stray_req: got req=%0b addr=%08h want 1 0", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    fetch_one(32'h0030_0193);
    n_vec++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, 32'h0030_0193}) begin n_err++;
      $display("FAIL post_rst: got v=%0b pc=%08h i=%08h want 1 0 00300193", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_redirect_hold();
    stall_id = 1'b1;
    tick();  // grant of 0x4
    imem_rvalid = 1'b1; imem_rdata = 32'h0070_0393;
    tick();  // parked
    imem_rvalid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n_vec++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_err++;
      $display("FAIL hold_flush: got v=%0b i=%08h want 0 %08h", id_valid, id_instr, NOP); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin n_err++;
      $display("FAIL hold_req: got req=%0b addr=%08h want 1 300", imem_req, imem_addr); end
    stall_id = 1'b0;
    tick();  // grant of 0x300
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL hold_drop: got v=%0b want 0", id_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0080_0413;
    tick();
    imem_rvalid = 1'b0;
    n_vec++; if ({id_pc, id_instr} !== {32'h300, 32'h0080_0413}) begin n_err++;
      $display("FAIL hold_next: got pc=%08h i=%08h want 300 00800413", id_pc, id_instr); end
  endtask

  task automatic test_wrap_mask();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++;
      $display("FAIL wrap_req: got req=%0b addr=%08h want 1 fffffffc", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    fetch_one(32'h0000_0013);
    n_vec++; if ({id_pc, imem_addr} !== {32'hFFFF_FFFC, 32'h0}) begin n_err++;
      $display("FAIL wrap: got pc=%08h addr=%08h want fffffffc 0", id_pc, imem_addr); end
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h402;
    tick();
    redirect = 1'b0;
`ifdef IFID_MISALIGN_TRAP_EN
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mis_noreq: got %0b want 0", imem_req); end
    tick();
    n_vec++; if ({id_valid, id_misalign, id_pc, id_instr} !== {1'b1, 1'b1, 32'h402, NOP}) begin n_err++;
      $display("FAIL mis_load: got v=%0b m=%0b pc=%08h i=%08h want 1 1 402 %08h", id_valid, id_misalign, id_pc, id_instr, NOP); end
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h404}) begin n_err++;
      $display("FAIL mis_resume: got req=%0b addr=%08h want 1 404", imem_req, imem_addr); end
`else
    n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h400}) begin n_err++;
      $display("FAIL mask: got req=%0b addr=%08h want 1 400", imem_req, imem_addr); end
`endif
    imem_gnt = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_gnt_wait();
    test_redirect_rvalid();
    test_reset_midfetch();
    test_redirect_hold();
    test_wrap_mask();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the RV32I core.
- Owns the PC and fetches from a single-outstanding-request instruction memory port.
- Registers the fetched word and drives the decoded fields opcode, funct3 and funct7 directly into ctrl_unit, plus the register indices and PC for the ID stage.
- Handles ID-stage stalls and branch/jump redirects, including squashing of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address
NOP_INSTR, 32'h0000_0013, word presented on the IF/ID outputs when invalid or flushed (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall_id  in  1  ID cannot accept a new instruction; hold the IF/ID register
redirect  in  1  branch/jump taken; one-cycle pulse
redirect_pc  in  32  target address when redirect=1
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  memory accepted request this cycle (req & gnt = handshake)
imem_rvalid  in  1  read data valid, at least 1 cycle after the accepting gnt
imem_rdata  in  32  instruction word
id_valid  out  1  IF/ID register holds a live instruction
id_pc  out  32  PC of the held instruction
id_instr  out  32  held instruction word
opcode  out  7  id_instr[6:0]
funct3  out  3  id_instr[14:12]
funct7  out  7  id_instr[31:25]
rd  out  5  id_instr[11:7]
rs1  out  5  id_instr[19:15]
rs2  out  5  id_instr[24:20]

Behaviour:
Reset (async assert, sync release):
- pc=RESET_PC, state=S_REQ, imem_req=0 while rst is high.
- id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC, kill=0.

Decoded field outputs:
- opcode, funct3, funct7, rd, rs1 and rs2 are pure slices of id_instr.
- When id_valid=0 they reflect NOP_INSTR.

S_REQ:
- imem_req=1 and imem_addr=pc.
- On gnt: capture fetch_pc=pc, set pc=pc+4 (32-bit wrap, FFFF_FFFC+4 -> 0), go to S_RESP.

S_RESP:
- imem_req=0; wait for imem_rvalid.
- On rvalid with kill=0 and IF/ID free: load the IF/ID register with id_instr=rdata, id_pc=fetch_pc, id_valid=1, then go to S_REQ.
- On rvalid with kill=0 and IF/ID blocked: buffer the word and go to S_HOLD.
- On rvalid with kill=1: discard the word, clear kill, go to S_REQ.

IF/ID free condition:
- Free when stall_id=0 or id_valid=0.

S_HOLD:
- imem_req=0.
- When the IF/ID register becomes free, move the buffered word in and go to S_REQ.

Stall (stall_id=1 with id_valid=1):
- id_* outputs hold unchanged.
- Consumption by ID happens on any cycle with id_valid=1 and stall_id=0. If no new word is loaded that cycle, id_valid goes to 0 next cycle.

Redirect (redirect=1) has priority over everything except reset:
- pc <= redirect_pc.
- id_valid <= 0 and id_instr <= NOP_INSTR next cycle, even if stall_id=1.
- In S_RESP, or in S_REQ with gnt the same cycle: set kill=1 so the in-flight response is discarded. The state goes to or stays in S_RESP, and pc takes redirect_pc, not pc+4.
- In S_HOLD: drop the buffer and go to S_REQ.
- Redirect coinciding with rvalid in S_RESP: the word is discarded and kill stays 0, since that response is the in-flight one. Go to S_REQ.

Latency:
- With a 1-cycle memory and no stalls, the instruction at PC appears on id_* 2 cycles after its request is granted.
- Throughput is 1 instruction per 2 cycles; single outstanding request is by design.

Other rules:
- imem_addr[1:0] is always 0; pc[1:0] is forced to 0 on load.
- Reset mid-fetch abandons the transaction; any later rvalid is ignored until a request is granted.

Optional Feature:
- Macro: IFID_MISALIGN_TRAP_EN.
- With the macro defined:
  - Adds output id_misalign (1 bit, reset 0).
  - When redirect_pc[1:0]!=0, the next IF/ID load carries id_misalign=1, id_instr=NOP_INSTR and id_pc=the unmasked redirect_pc.
  - No memory fetch is issued for it; fetching then resumes at the masked address + 4.
- Without the macro: no port; redirect_pc[1:0] is silently masked.

Test Plan:
1. Reset release with RESET_PC=0, 1-cycle memory returning 32'h0000_0033 (add) -> requests at 0,4,8; id_valid=1 with opcode=7'b0110011, funct3=0, funct7=0, id_pc=0.
2. stall_id=1 for 3 cycles while id holds 32'h0000_2003 (lw) at pc=4 -> id_instr and id_pc frozen; next word waits in S_HOLD with no imem_req; after release the next word loads with id_pc=8.
3. redirect=1, redirect_pc=32'h100 while the fetch of 0x8 is outstanding -> the 0x8 response is discarded; the next request has imem_addr=0x100; id_valid=0 until the 0x100 word arrives.
4. imem_gnt held low for 4 cycles -> imem_req stays 1 with imem_addr stable; no id_valid change.
5. Redirect and rvalid in the same cycle, with imem_rvalid delayed 3 cycles -> word dropped; next imem_addr=redirect_pc; no duplicate or stale instruction reaches id_instr.
6. Assert rst mid-S_RESP, then send a stray rvalid after release -> outputs return to reset values immediately; the stray word is ignored; first request is at RESET_PC.
